// File: rtl/commu_frame.sv
// Frame sequencer: derives payload/frame lengths from a sample-rate code and walks HEAD/LOAD/TAIL/CRC.
// Define COMMU_SIM_LEN_EN to shrink the payload unit to SAMPLE_UNIT/100 for short simulation frames.
module commu_frame #(
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned NCH         = 1,
  parameter int unsigned SAMPLE_UNIT = 900,
  parameter int unsigned MAX_SAMPLE  = 20,
  parameter int unsigned LEN_HEAD    = 12,
  parameter int unsigned LEN_TAIL    = 0,
  parameter int unsigned LEN_CRC     = 1
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [7:0]       cfg_sample,
  input  logic             start,
  input  logic             tick,
  output logic [LEN_W-1:0] len_load,
  output logic [LEN_W-1:0] len_pkg,
  output logic             cfg_err,
  output logic             busy,
  output logic [2:0]       phase,
  output logic [LEN_W-1:0] idx,
  output logic             frm_done
);

`ifdef COMMU_SIM_LEN_EN
  localparam int unsigned Unit = SAMPLE_UNIT / 100;
`else
  localparam int unsigned Unit = SAMPLE_UNIT;
`endif

  localparam longint unsigned LenMax = (64'd1 << LEN_W) - 64'd1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHead = 3'd1,
    StLoad = 3'd2,
    StTail = 3'd3,
    StCrc  = 3'd4,
    StDone = 3'd5
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_load_q, len_load_d;
  logic [LEN_W-1:0] len_pkg_q, len_pkg_d;
  logic             err_load_q, err_load_d;
  logic             err_pkg_q, err_pkg_d;

  // Length pipeline: stage 1 payload product, stage 2 frame sum; both saturate on overflow.
  longint unsigned sample_eff, prod, sum;
  logic            sample_bad;

  always_comb begin
    sample_bad = (cfg_sample == 8'd0) || (64'(cfg_sample) > 64'(MAX_SAMPLE));
    sample_eff = sample_bad ? 64'(MAX_SAMPLE) : 64'(cfg_sample);
    prod       = sample_eff * 64'(NCH) * 64'(Unit);
    sum        = 64'(LEN_HEAD) + 64'(len_load_q) + 64'(LEN_TAIL) + 64'(LEN_CRC);
    len_load_d = (prod > LenMax) ? '1 : prod[LEN_W-1:0];
    err_load_d = sample_bad || (prod > LenMax);
    len_pkg_d  = (sum > LenMax) ? '1 : sum[LEN_W-1:0];
    err_pkg_d  = (sum > LenMax);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      len_load_q <= '0;
      len_pkg_q  <= '0;
      err_load_q <= 1'b0;
      err_pkg_q  <= 1'b0;
    end else if (phase_q == StIdle) begin
      len_load_q <= len_load_d;
      len_pkg_q  <= len_pkg_d;
      err_load_q <= err_load_d;
      err_pkg_q  <= err_pkg_d;
    end
  end

  logic [LEN_W-1:0] cur_len;
  logic [4:1]       live;
  logic             last_word;
  phase_e           nxt;

  always_comb begin
    unique case (phase_q)
      StHead:  cur_len = LEN_W'(LEN_HEAD);
      StLoad:  cur_len = len_load_q;
      StTail:  cur_len = LEN_W'(LEN_TAIL);
      StCrc:   cur_len = LEN_W'(LEN_CRC);
      default: cur_len = '0;
    endcase
    last_word = (idx_q == cur_len - LEN_W'(1));
    live      = {LEN_CRC != 0, LEN_TAIL != 0, len_load_q != '0, LEN_HEAD != 0};
    // Scan downwards so the nearest later phase with non-zero length wins.
    nxt = StDone;
    for (int p = 4; p >= 1; p--) begin
      if ((p > int'(phase_q)) && live[p]) nxt = phase_e'(3'(p));
    end
  end

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    unique case (phase_q)
      StIdle: begin
        if (start) begin
          phase_d = nxt;
          idx_d   = '0;
        end
      end
      StHead, StLoad, StTail, StCrc: begin
        if (tick) begin
          if (last_word) begin
            phase_d = nxt;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      StDone: begin
        phase_d = StIdle;
        idx_d   = '0;
      end
      default: begin
        phase_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= StIdle;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  assign len_load = len_load_q;
  assign len_pkg  = len_pkg_q;
  assign cfg_err  = err_load_q | err_pkg_q;
  assign phase    = phase_q;
  assign idx      = idx_q;
  assign busy     = (phase_q == StHead) || (phase_q == StLoad) ||
                    (phase_q == StTail) || (phase_q == StCrc);
  assign frm_done = (phase_q == StDone);

endmodule

// File: tb/tb_commu_frame.sv
// Self-checking bench for commu_frame: randomized cfg codes and tick patterns against a length/word-list model.
module tb_commu_frame;

`ifdef COMMU_SIM_LEN_EN
  localparam int UNIT = 9;
`else
  localparam int UNIT = 900;
`endif
  localparam int HEAD = 12;
  localparam int CRC  = 1;
  localparam int MAXS = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  cfg_sample = 8'd20;
  logic        start = 1'b0;
  logic        tick = 1'b0;
  logic        start2 = 1'b0;
  logic        tick2 = 1'b0;
  logic [15:0] len_load, len_pkg, idx;
  logic [15:0] len_load2, len_pkg2, idx2;
  logic        cfg_err, busy, frm_done;
  logic        cfg_err2, busy2, frm_done2;
  logic [2:0]  phase, phase2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  commu_frame dut (
    .clk_sys(clk), .rst_n(rst_n), .cfg_sample(cfg_sample), .start(start), .tick(tick),
    .len_load(len_load), .len_pkg(len_pkg), .cfg_err(cfg_err), .busy(busy),
    .phase(phase), .idx(idx), .frm_done(frm_done)
  );

  commu_frame #(.NCH(4)) dut4 (
    .clk_sys(clk), .rst_n(rst_n), .cfg_sample(cfg_sample), .start(start2), .tick(tick2),
    .len_load(len_load2), .len_pkg(len_pkg2), .cfg_err(cfg_err2), .busy(busy2),
    .phase(phase2), .idx(idx2), .frm_done(frm_done2)
  );

  function automatic longint m_raw(int s, int nch);
    int e = (s == 0 || s > MAXS) ? MAXS : s;
    return longint'(e) * nch * UNIT;
  endfunction

  function automatic longint m_load(int s, int nch);
    longint p = m_raw(s, nch);
    return (p > 65535) ? 65535 : p;
  endfunction

  function automatic longint m_pkg(int s, int nch);
    longint t = HEAD + m_load(s, nch) + CRC;
    return (t > 65535) ? 65535 : t;
  endfunction

  function automatic bit m_err(int s, int nch);
    return (s == 0) || (s > MAXS) || (m_raw(s, nch) > 65535) ||
           (HEAD + m_load(s, nch) + CRC > 65535);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (phase !== 3'd0 || idx !== 16'd0 || busy !== 1'b0 || frm_done !== 1'b0 ||
        cfg_err !== 1'b0 || len_load !== 16'd0 || len_pkg !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: phase=%0d idx=%0d busy=%b done=%b err=%b load=%0d pkg=%0d, want all 0",
               phase, idx, busy, frm_done, cfg_err, len_load, len_pkg);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (len_load !== 16'(m_load(20, 1))) begin
      n_bad++;
      $display("FAIL reset_len_load: got %0d want %0d", len_load, m_load(20, 1));
    end
    step();
    n_cmp++;
    if (len_pkg !== 16'(m_pkg(20, 1)) || cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_len_pkg: got %0d err=%b want %0d err=0", len_pkg, cfg_err, m_pkg(20, 1));
    end
  endtask

  task automatic test_lengths();
    int s;
    for (int i = 0; i < 16; i++) begin
      case (i)
        0: s = 20;
        1: s = 7;
        2: s = 0;
        3: s = 21;
        4: s = 5;
        default: s = $urandom_range(0, 255);
      endcase
      cfg_sample = 8'(s);
      step();
      n_cmp++;
      if (len_load !== 16'(m_load(s, 1)) || cfg_err !== m_err(s, 1)) begin
        n_bad++;
        $display("FAIL len_load cfg=%0d: got %0d err=%b want %0d err=%b",
                 s, len_load, cfg_err, m_load(s, 1), m_err(s, 1));
      end
      step();
      n_cmp++;
      if (len_pkg !== 16'(m_pkg(s, 1)) || cfg_err !== m_err(s, 1)) begin
        n_bad++;
        $display("FAIL len_pkg cfg=%0d: got %0d err=%b want %0d err=%b",
                 s, len_pkg, cfg_err, m_pkg(s, 1), m_err(s, 1));
      end
      n_cmp++;
      if (len_load2 !== 16'(m_load(s, 4)) || len_pkg2 !== 16'(m_pkg(s, 4)) ||
          cfg_err2 !== m_err(s, 4)) begin
        n_bad++;
        $display("FAIL nch4_len cfg=%0d: got load=%0d pkg=%0d err=%b want %0d %0d %b", s,
                 len_load2, len_pkg2, cfg_err2, m_load(s, 4), m_pkg(s, 4), m_err(s, 4));
      end
`ifndef COMMU_SIM_LEN_EN
      if (i < 3) begin
        n_cmp++;
        if ((i == 0 && (len_load !== 16'd18000 || len_pkg !== 16'd18013 || cfg_err !== 1'b0)) ||
            (i == 1 && (len_load !== 16'd6300 || len_pkg !== 16'd6313 || cfg_err !== 1'b0)) ||
            (i == 2 && (len_load !== 16'd18000 || cfg_err !== 1'b1))) begin
          n_bad++;
          $display("FAIL directed_len cfg=%0d: got load=%0d pkg=%0d err=%b", s, len_load, len_pkg,
                   cfg_err);
        end
        if (i == 0) begin
          n_cmp++;
          if (len_load2 !== 16'd65535 || cfg_err2 !== 1'b1) begin
            n_bad++;
            $display("FAIL nch4_saturate: got load=%0d err=%b want 65535 err=1", len_load2, cfg_err2);
          end
        end
      end
`endif
    end
  endtask

  task automatic test_frame(input int s);
    int exp_ph[$];
    int exp_ix[$];
    int budget, cyc;
    bit t;
    cfg_sample = 8'(s);
    repeat (3) step();
    for (int i = 0; i < HEAD; i++) begin exp_ph.push_back(1); exp_ix.push_back(i); end
    for (int i = 0; i < int'(m_load(s, 1)); i++) begin exp_ph.push_back(2); exp_ix.push_back(i); end
    for (int i = 0; i < CRC; i++) begin exp_ph.push_back(4); exp_ix.push_back(i); end
    budget = 4 * exp_ph.size() + 50;
    cyc = 0;
    start = 1'b1;
    tick = 1'b1;
    step();
    start = 1'b0;
    tick = 1'b0;
    while (exp_ph.size() > 0 && cyc < budget) begin
      n_cmp++;
      if (phase !== 3'(exp_ph[0]) || idx !== 16'(exp_ix[0]) || busy !== 1'b1 ||
          frm_done !== 1'b0) begin
        n_bad++;
        $display("FAIL frame_word: got phase=%0d idx=%0d busy=%b done=%b want phase=%0d idx=%0d busy=1",
                 phase, idx, busy, frm_done, exp_ph[0], exp_ix[0]);
      end
      t = ($urandom_range(0, 3) != 0);
      tick = t;
      start = ($urandom_range(0, 7) == 0);
      step();
      if (t) void'(exp_ph.pop_front());
      if (t) void'(exp_ix.pop_front());
      cyc++;
    end
    tick = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (exp_ph.size() != 0) begin
      n_bad++;
      $display("FAIL frame_timeout: %0d words left, want 0", exp_ph.size());
    end
    n_cmp++;
    if (phase !== 3'd5 || frm_done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_done: got phase=%0d done=%b busy=%b want phase=5 done=1 busy=0",
               phase, frm_done, busy);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_cmp++;
    if (phase !== 3'd0 || idx !== 16'd0 || frm_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_idle: got phase=%0d idx=%0d done=%b busy=%b want 0 0 0 0",
               phase, idx, frm_done, busy);
    end
  endtask

  task automatic test_midframe_cfg();
    int cyc = 0;
    int budget = int'(m_pkg(20, 1)) + 20;
    cfg_sample = 8'd20;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_sample = 8'd5;
    tick = 1'b1;
    while (phase != 3'd5 && cyc < budget) begin
      n_cmp++;
      if (len_pkg !== 16'(m_pkg(20, 1)) || len_load !== 16'(m_load(20, 1))) begin
        n_bad++;
        $display("FAIL frozen_len: got load=%0d pkg=%0d want %0d %0d", len_load, len_pkg,
                 m_load(20, 1), m_pkg(20, 1));
      end
      step();
      cyc++;
    end
    tick = 1'b0;
    n_cmp++;
    if (phase !== 3'd5) begin
      n_bad++;
      $display("FAIL midframe_timeout: phase=%0d want 5", phase);
    end
    repeat (3) step();
    n_cmp++;
    if (len_pkg !== 16'(m_pkg(5, 1)) || len_load !== 16'(m_load(5, 1))) begin
      n_bad++;
      $display("FAIL requal_len: got load=%0d pkg=%0d want %0d %0d", len_load, len_pkg,
               m_load(5, 1), m_pkg(5, 1));
    end
  endtask

  task automatic test_reset_in_load();
    cfg_sample = 8'd1;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    tick = 1'b1;
    repeat (HEAD + 2) step();
    tick = 1'b0;
    n_cmp++;
    if (phase !== 3'd2 || idx !== 16'd2) begin
      n_bad++;
      $display("FAIL pre_reset_load: got phase=%0d idx=%0d want 2 2", phase, idx);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (phase !== 3'd0 || idx !== 16'd0 || busy !== 1'b0 || frm_done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_abort: got phase=%0d idx=%0d busy=%b done=%b want 0 0 0 0",
               phase, idx, busy, frm_done);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (frm_done !== 1'b0 || phase !== 3'd0) begin
        n_bad++;
        $display("FAIL abort_no_done: got phase=%0d done=%b want 0 0", phase, frm_done);
      end
    end
    rst_n = 1'b1;
    step();
    step();
    n_cmp++;
    if (len_pkg !== 16'(m_pkg(1, 1))) begin
      n_bad++;
      $display("FAIL post_abort_len: got %0d want %0d", len_pkg, m_pkg(1, 1));
    end
  endtask

  initial begin
    test_reset();
    test_lengths();
    test_frame(1);
    test_frame(1);
    test_midframe_cfg();
    test_reset_in_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/commu_frame.md
COMMU_FRAME -- requirements
Module: commu_frame

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of all length outputs and counters.
REQ-002 SHALL have parameter NCH, default 1, channel count multiplying the payload length.
REQ-003 SHALL have parameter SAMPLE_UNIT, default 900, payload words per unit of cfg_sample per channel.
REQ-004 SHALL have parameter MAX_SAMPLE, default 20, largest legal cfg_sample.
REQ-005 SHALL have parameters LEN_HEAD, LEN_TAIL and LEN_CRC, defaults 12, 0 and 1, phase lengths in words.
REQ-006 SHALL have port clk_sys, input, 1, system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port cfg_sample, input, 8, sample-rate code.
REQ-009 SHALL have port start, input, 1, single-cycle frame request.
REQ-010 SHALL have port tick, input, 1, one word emitted downstream this cycle.
REQ-011 SHALL have port len_load, output, LEN_W, payload length.
REQ-012 SHALL have port len_pkg, output, LEN_W, total frame length.
REQ-013 SHALL have port cfg_err, output, 1, illegal code or overflow.
REQ-014 SHALL have port busy, output, 1, frame in progress.
REQ-015 SHALL have port phase, output, 3, phase code: 0 IDLE, 1 HEAD, 2 LOAD, 3 TAIL, 4 CRC, 5 DONE.
REQ-016 SHALL have port idx, output, LEN_W, word index within the current phase.
REQ-017 SHALL have port frm_done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-018 SHALL, while phase is IDLE, register len_load <= cfg_sample*NCH*SAMPLE_UNIT one cycle after cfg_sample is sampled.
REQ-019 SHALL register len_pkg <= LEN_HEAD+len_load+LEN_TAIL+LEN_CRC one cycle after len_load, giving 2-cycle cfg-to-len_pkg latency.
REQ-020 SHALL treat cfg_sample of 0 or greater than MAX_SAMPLE as MAX_SAMPLE and set cfg_err=1, registered with len_load.
REQ-021 SHALL, if any sum or product exceeds 2^LEN_W-1, saturate that result to all-ones and set cfg_err=1.
REQ-022 SHALL hold len_load, len_pkg and cfg_err frozen while phase is not IDLE; cfg_sample changes in that time take effect only after return to IDLE.
REQ-023 SHALL move from IDLE to HEAD on start; start SHALL be ignored in every other phase.
REQ-024 SHALL increment idx on tick, advance to the next non-zero-length phase after the last word of a phase (idx = len-1), and clear idx to 0 on every phase change.
REQ-025 SHALL skip any phase whose length is 0 (default TAIL), going directly from LOAD to CRC.
REQ-026 SHALL go from the last CRC tick to DONE for exactly one cycle with frm_done=1, then return to IDLE.
REQ-027 SHALL ignore tick in IDLE and DONE, including a tick coincident with start.
REQ-028 SHALL drive busy=1 exactly when phase is one of HEAD, LOAD, TAIL or CRC.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force phase=IDLE, idx=0, busy=0, frm_done=0, cfg_err=0, len_load=0 and len_pkg=0, aborting any frame without frm_done.
REQ-030 SHALL, after reset release, produce valid lengths 2 cycles later without requiring start.

Configuration
REQ-031 SHALL, when macro COMMU_SIM_LEN_EN is defined, use SAMPLE_UNIT/100 (9 by default) as the unit for short simulation frames.
REQ-032 SHALL, when COMMU_SIM_LEN_EN is undefined, use SAMPLE_UNIT unchanged; no other behaviour differs.

Verification
REQ-033 SHALL verify: cfg_sample=20, no macro -> len_load=18000 after 1 cycle, len_pkg=18013 after 2 cycles, cfg_err=0.
REQ-034 SHALL verify: cfg_sample=7, no macro -> len_load=6300, len_pkg=6313; cfg_sample=0 -> len_load=18000, cfg_err=1.
REQ-035 SHALL verify: COMMU_SIM_LEN_EN with cfg_sample=1, start, then 22 ticks -> HEAD idx 0..11, LOAD 0..8, CRC 0, TAIL never entered, frm_done the cycle after tick 22.
REQ-036 SHALL verify: cfg_sample changed 20->5 mid-frame -> len_pkg stays 18013 until IDLE, then becomes 4513 within 2 cycles.
REQ-037 SHALL verify: rst_n low during LOAD -> phase=0, idx=0, busy=0 immediately, with no frm_done pulse.
REQ-038 SHALL verify: NCH=4, cfg_sample=20, LEN_W=16 -> len_load saturates to 65535 and cfg_err=1.
